// File: rtl/mux_nx1_scan.sv
// mux_nx1_scan: N-channel, W-bit registered multiplexer.
// Supports a manual channel select and an automatic round-robin scan that
// stays on each channel for a programmable number of accepted samples.
// The output side uses a valid/ready handshake, so the consumer can stall
// the scan. Disabling the block loads an empty (invalid, all-zero) sample.
module mux_nx1_scan #(
    parameter int CH    = 4,
    parameter int W     = 1,
    parameter int DWELL = 1,
    parameter int SW    = $clog2(CH)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic            mode,
    input  logic [SW-1:0]   sel,
    input  logic [CH*W-1:0] din,
    input  logic            out_ready,
    output logic [W-1:0]    out_data,
    output logic [SW-1:0]   out_ch,
    output logic            out_valid,
    output logic            out_last
);

    // A dwell counter needs at least one bit, even when DWELL is 1.
    localparam int DCW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [SW-1:0]  LAST_CH = SW'(CH - 1);
    localparam logic [DCW-1:0] LAST_DW = DCW'(DWELL - 1);

    logic [SW-1:0]  ptr;
    logic [DCW-1:0] dcnt;
    logic           load;
    logic [SW-1:0]  sel_clamped;
    logic [SW-1:0]  idx;
    logic [W-1:0]   picked;
    logic           dwell_done;
    logic           ch_last;

    // Outputs may only change when the register is empty or being drained.
    assign load       = !out_valid || out_ready;
    assign dwell_done = (dcnt == LAST_DW);
    assign ch_last    = (ptr == LAST_CH);

    // Out-of-range manual selects fall back to the highest channel.
    always_comb begin
        sel_clamped = sel;
        if (32'(sel) >= CH) begin
            sel_clamped = LAST_CH;
        end
    end

    // Pick the channel index for this load, then the matching input slice.
    always_comb begin
        idx    = mode ? ptr : sel_clamped;
        picked = '0;
        for (int i = 0; i < CH; i++) begin
            if (32'(idx) == i) begin
                picked = din[i*W +: W];
            end
        end
    end

    // Output register and scan state, updated only in load slots.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data  <= '0;
            out_ch    <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            ptr       <= '0;
            dcnt      <= '0;
        end else if (load) begin
            if (!en) begin
                out_data  <= '0;
                out_ch    <= '0;
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end else if (!mode) begin
                out_data  <= picked;
                out_ch    <= sel_clamped;
                out_valid <= 1'b1;
                out_last  <= 1'b0;
                ptr       <= '0;
                dcnt      <= '0;
            end else begin
                out_data  <= picked;
                out_ch    <= ptr;
                out_valid <= 1'b1;
                out_last  <= ch_last && dwell_done;
                if (dwell_done) begin
                    dcnt <= '0;
                    ptr  <= ch_last ? '0 : ptr + SW'(1);
                end else begin
                    dcnt <= dcnt + DCW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_mux_nx1_scan.sv
// tb_mux_nx1_scan: directed self-checking bench for mux_nx1_scan.
// dut_a is a 4x8 instance for the manual-select checks; dut_b is a 3x8
// instance with a dwell of 2 for scan, stall, enable and mode checks.
module tb_mux_nx1_scan;

    logic        clk;
    logic        rst_n;

    logic        en_a, mode_a, ready_a;
    logic [1:0]  sel_a;
    logic [31:0] din_a;
    logic [7:0]  data_a;
    logic [1:0]  ch_a;
    logic        valid_a, last_a;

    logic        en_b, mode_b, ready_b;
    logic [1:0]  sel_b;
    logic [23:0] din_b;
    logic [7:0]  data_b;
    logic [1:0]  ch_b;
    logic        valid_b, last_b;

    int n_checks;
    int n_fail;

    mux_nx1_scan #(.CH(4), .W(8), .DWELL(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .en(en_a), .mode(mode_a), .sel(sel_a),
        .din(din_a), .out_ready(ready_a), .out_data(data_a), .out_ch(ch_a),
        .out_valid(valid_a), .out_last(last_a)
    );

    mux_nx1_scan #(.CH(3), .W(8), .DWELL(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en_b), .mode(mode_b), .sel(sel_b),
        .din(din_b), .out_ready(ready_b), .out_data(data_b), .out_ch(ch_b),
        .out_valid(valid_b), .out_last(last_b)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Checks the full output bundle of dut_b in one call.
    task automatic check_b(input string tag, input logic v, input logic [1:0] ch,
                           input logic [7:0] d, input logic l);
        check_output({tag, ".valid"}, 32'(valid_b), 32'(v));
        check_output({tag, ".ch"},    32'(ch_b),    32'(ch));
        check_output({tag, ".data"},  32'(data_b),  32'(d));
        check_output({tag, ".last"},  32'(last_b),  32'(l));
    endtask

    // Advance one clock and step just past the edge before sampling.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Directed stimulus sequence with hand-computed expectations.
    initial begin
        logic [7:0] man_exp [4];
        logic [1:0] scan_ch [7];
        logic       scan_last [7];
        logic [7:0] chan_data [3];

        man_exp   = '{8'h11, 8'h22, 8'h33, 8'h44};
        scan_ch   = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd0};
        scan_last = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        chan_data = '{8'hA0, 8'hB1, 8'hC2};
        n_checks  = 0;
        n_fail    = 0;

        // Reset held with random inputs active on both instances.
        rst_n   = 1'b0;
        din_a   = $urandom;
        din_b   = 24'($urandom);
        sel_a   = 2'($urandom);
        sel_b   = 2'($urandom);
        mode_a  = 1'($urandom);
        mode_b  = 1'($urandom);
        en_a    = 1'b1;
        en_b    = 1'b1;
        ready_a = 1'b1;
        ready_b = 1'b1;
        repeat (3) tick;
        check_output("rst_a.valid", 32'(valid_a), 32'd0);
        check_output("rst_a.data",  32'(data_a),  32'd0);
        check_output("rst_a.ch",    32'(ch_a),    32'd0);
        check_output("rst_a.last",  32'(last_a),  32'd0);
        check_b("rst_b", 1'b0, 2'd0, 8'h00, 1'b0);
        check_output("rst_b.ptr",  32'(dut_b.ptr),  32'd0);
        check_output("rst_b.dcnt", 32'(dut_b.dcnt), 32'd0);

        // Manual select on dut_a; dut_b stays disabled so its scan state is idle.
        din_a  = 32'h44332211;
        mode_a = 1'b0;
        sel_a  = 2'd0;
        din_b  = 24'hC2B1A0;
        en_b   = 1'b0;
        mode_b = 1'b0;
        sel_b  = 2'd0;
        rst_n  = 1'b1;
        $display("[TB] manual select");
        for (int i = 0; i < 4; i++) begin
            sel_a = 2'(i);
            tick;
            check_output($sformatf("man%0d.data", i),  32'(data_a),  32'(man_exp[i]));
            check_output($sformatf("man%0d.ch", i),    32'(ch_a),    i);
            check_output($sformatf("man%0d.valid", i), 32'(valid_a), 32'd1);
            check_output($sformatf("man%0d.last", i),  32'(last_a),  32'd0);
        end
        check_output("man.b_idle", 32'(valid_b), 32'd0);

        // Round-robin scan with two samples per channel and a frame wrap.
        $display("[TB] scan");
        mode_b = 1'b1;
        en_b   = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tick;
            check_b($sformatf("scan%0d", i), 1'b1, scan_ch[i], chan_data[scan_ch[i]], scan_last[i]);
        end

        // Stall in the middle of channel 0's dwell; held sample must not change.
        $display("[TB] stall");
        ready_b = 1'b0;
        din_b   = 24'hC2B15A;
        for (int i = 0; i < 5; i++) begin
            tick;
            check_b($sformatf("stall%0d", i), 1'b1, 2'd0, 8'hA0, 1'b0);
        end
        din_b   = 24'hC2B1A0;
        ready_b = 1'b1;
        tick;
        check_b("resume", 1'b1, 2'd0, 8'hA0, 1'b0);

        // Enable gate for two cycles with the scan pointer at channel 1.
        $display("[TB] enable gate");
        en_b = 1'b0;
        tick;
        check_b("gate0", 1'b0, 2'd0, 8'h00, 1'b0);
        tick;
        check_b("gate1", 1'b0, 2'd0, 8'h00, 1'b0);
        en_b = 1'b1;
        tick;
        check_b("ungate0", 1'b1, 2'd1, 8'hB1, 1'b0);
        tick;
        check_b("ungate1", 1'b1, 2'd1, 8'hB1, 1'b0);
        tick;
        check_b("ungate2", 1'b1, 2'd2, 8'hC2, 1'b0);

        // Dropping enable while stalled must keep the pending sample.
        ready_b = 1'b0;
        en_b    = 1'b0;
        tick;
        check_b("hold0", 1'b1, 2'd2, 8'hC2, 1'b0);
        tick;
        check_b("hold1", 1'b1, 2'd2, 8'hC2, 1'b0);
        ready_b = 1'b1;
        tick;
        check_b("accepted", 1'b0, 2'd0, 8'h00, 1'b0);

        // Ready is irrelevant while empty; scan continues with the frame end.
        ready_b = 1'b0;
        en_b    = 1'b1;
        tick;
        check_b("empty_load", 1'b1, 2'd2, 8'hC2, 1'b1);

        // Out-of-range manual select, then manual to scan restarts at channel 0.
        $display("[TB] mode switch");
        ready_b = 1'b1;
        mode_b  = 1'b0;
        sel_b   = 2'd3;
        tick;
        check_b("sel_clamp", 1'b1, 2'd2, 8'hC2, 1'b0);
        sel_b = 2'd1;
        tick;
        check_b("sel1", 1'b1, 2'd1, 8'hB1, 1'b0);
        mode_b = 1'b1;
        tick;
        check_b("to_scan0", 1'b1, 2'd0, 8'hA0, 1'b0);
        tick;
        check_b("to_scan1", 1'b1, 2'd0, 8'hA0, 1'b0);
        tick;
        check_b("to_scan2", 1'b1, 2'd1, 8'hB1, 1'b0);

        // Asynchronous reset while stalled clears everything at once.
        $display("[TB] reset mid-stall");
        ready_b = 1'b0;
        tick;
        check_b("pre_rst", 1'b1, 2'd1, 8'hB1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_b("async_rst", 1'b0, 2'd0, 8'h00, 1'b0);
        check_output("async_rst.ptr",  32'(dut_b.ptr),  32'd0);
        check_output("async_rst.dcnt", 32'(dut_b.dcnt), 32'd0);
        tick;
        rst_n   = 1'b1;
        ready_b = 1'b1;
        tick;
        check_b("post_rst", 1'b1, 2'd0, 8'hA0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mux_nx1_scan.md
# mux_nx1_scan

Parametrised N-channel, W-bit registered multiplexer. It succeeds the fixed 4x1 combinational mux and its gated variant. It offers two modes: manual select, and automatic round-robin scan with a programmable dwell per channel. An enable gate forces the output to zero, and the output side uses a valid/ready handshake so a downstream consumer can stall the scan. It sits between parallel sampled sources and a single serial consumer, such as a display driver or a UART framer.

## Interface
Parameters:
- CH, 4, number of input channels (>= 2).
- W, 1, bit width of each channel.
- DWELL, 1, accepted samples taken from each channel before scan advances (>= 1).
- SW, $clog2(CH), select/pointer width (derived; do not override).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  enable.
  - 0: next load produces zero data, not valid.
- mode  in  1  channel select mode.
  - 0: manual select via sel.
  - 1: automatic round-robin scan.
- sel  in  SW  manual channel select.
- din  in  CH*W  flat input; channel i occupies din[i*W +: W].
- out_ready  in  1  consumer accepts the current output.
- out_data  out  W  registered selected data.
- out_ch  out  SW  channel index of out_data.
- out_valid  out  1  out_data/out_ch hold a valid sample.
- out_last  out  1  sample is the final dwell of channel CH-1 in scan mode (frame end).

## Operation
- Load slot: a cycle where (!out_valid || out_ready). Outputs update only in load slots. Otherwise all outputs, ptr and dcnt hold (stall).
- Load with en=0:
  - out_valid<=0, out_data<=0, out_ch<=0, out_last<=0.
  - ptr and dcnt frozen, not cleared.
- Load with en=1, mode=0 (manual):
  - out_data<=din[sel], out_ch<=sel, out_valid<=1, out_last<=0.
  - sel >= CH selects channel CH-1.
  - ptr and dcnt forced to 0.
- Load with en=1, mode=1 (scan):
  - out_data<=din[ptr], out_ch<=ptr, out_valid<=1.
  - out_last<=(ptr==CH-1 && dcnt==DWELL-1).
  - If dcnt==DWELL-1: dcnt<=0 and ptr advances. ptr goes from CH-1 to 0 (wrap), otherwise ptr+1.
  - Else dcnt<=dcnt+1.
- Scan state: ptr (SW bits, range 0..CH-1), dcnt (counter 0..DWELL-1).
  - Transition manual->scan always starts at channel 0, dwell 0.
- A pending valid sample is never dropped or altered:
  - Changes on en, mode or sel while stalled take effect only at the next load slot.
- Arithmetic:
  - ptr and dcnt compare against the parameters. They never exceed their ranges, including when CH is not a power of two.
  - No overflow states are reachable.

## Timing
- Reset (asynchronous, immediate): out_data=0, out_ch=0, out_valid=0, out_last=0, ptr=0, dcnt=0.
  - First load slot is the first rising edge after rst_n deasserts.
- Latency: 1 cycle from din/sel/en/mode sampled in a load slot to out_*.
- Throughput: one sample per cycle while out_ready=1.
- Simultaneous events:
  - out_ready=1 together with out_valid=1 in the same cycle completes the transfer and loads the next sample on that edge.
  - mode toggling in that same cycle uses the new mode for the load.
- Reset mid-scan or mid-stall clears everything at once. No partial sample is emitted.
- out_ready is ignored while out_valid=0.

## Test plan
- Reset: hold rst_n=0 with random inputs, then release.
  - All outputs and ptr/dcnt are 0 during reset.
  - First sample appears 1 cycle after release.
- Manual, CH=4, W=8, din={8'h44,8'h33,8'h22,8'h11}, out_ready=1, sel stepping 0,1,2,3:
  - out_data 11,22,33,44 on the following cycles, out_ch matching, out_last=0.
- Scan, CH=3, DWELL=2, out_ready=1:
  - out_ch sequence 0,0,1,1,2,2,0.
  - out_last=1 only on the second sample of channel 2.
  - Wrap back to 0.
- Stall: scan with out_ready=0 for 5 cycles mid-dwell.
  - out_data/out_ch/out_last constant while stalled.
  - Sequence resumes exactly where it stopped; no channel skipped.
- Enable gate, out_ready=1: drop en for 2 cycles during scan at ptr=1.
  - out_valid=0 and out_data=0 for 2 cycles.
  - Scan resumes at ptr=1.
  - If en drops while out_valid=1 and out_ready=0, the held sample persists until accepted.
- Mode switch and out-of-range select:
  - Switching manual->scan starts at ch 0.
  - With CH=3, sel=3 selects channel 2.
